// File: rtl/writeback_arb_pkg.sv
// Shared types and defaults for the writeback arbiter and its result buffer.
// Holds the starvation-guard state encodings and the x0 register index.
package writeback_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    localparam int REG_X0       = 0;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of {rd, result} pairs from the long-latency unit.
// Exposes per-entry valid bits and destinations so the top can run the decode hazard compare.
module wb_result_fifo
    import writeback_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [REGW-1:0]       pushRd_i,
    input  logic [XLEN-1:0]       pushData_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [REGW-1:0]       headRd_o,
    output logic [XLEN-1:0]       headData_o,
    output logic [DEPTH-1:0]      valid_o,
    output logic [DEPTH*REGW-1:0] rdVec_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [REGW-1:0]  rdMem_q   [DEPTH];
    logic [XLEN-1:0]  dataMem_q [DEPTH];
    logic [PTRW-1:0]  wptr_q;
    logic [PTRW-1:0]  rptr_q;
    logic [CNTW-1:0]  count_q;
    logic [DEPTH-1:0] valid_q;

    // Pop clears before push sets, so a slot reused in the same cycle stays valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (pop_i) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + PTRW'(1);
            end
            if (push_i) begin
                valid_q[wptr_q] <= 1'b1;
                wptr_q          <= wptr_q + PTRW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            rdMem_q[wptr_q]   <= pushRd_i;
            dataMem_q[wptr_q] <= pushData_i;
        end
    end

    always_comb begin
        rdVec_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdVec_o[i*REGW +: REGW] = rdMem_q[i];
        end
    end

    assign full_o     = (count_q == CNTW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign headRd_o   = rdMem_q[rptr_q];
    assign headData_o = dataMem_q[rptr_q];
    assign valid_o    = valid_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: pipeline result first, buffered long-latency results in idle slots.
// Define WB_ARB_STARVE_EN to enable the starvation guard (wait counter, PEND/FORCE states, StallWB).
module writeback_arbiter
    import writeback_arb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REGW     = 5,
    parameter int DEPTH    = DEF_DEPTH
`ifdef WB_ARB_STARVE_EN
    ,
    parameter int MAX_WAIT = DEF_MAX_WAIT
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [REGW-1:0] RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            MduValid,
    output logic            MduReady,
    input  logic [REGW-1:0] MduRd,
    input  logic [XLEN-1:0] MduResult,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    output logic            HazardPend,
    output logic            StallWB,
    output logic            RegWriteR,
    output logic [REGW-1:0] RdR,
    output logic [XLEN-1:0] ResultR
);

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [REGW-1:0]       headRd;
    logic [XLEN-1:0]       headResult;
    logic [DEPTH-1:0]      validVec;
    logic [DEPTH*REGW-1:0] rdVec;
    logic                  push;
    logic                  pop;
    logic                  pipeWrite;
    logic                  forceSlot;

    // Results aimed at x0 are acknowledged but never occupy a buffer slot.
    assign MduReady  = rst & ~fifoFull;
    assign push      = MduValid & MduReady & (MduRd != REGW'(REG_X0));
    assign pipeWrite = rst & RegWriteW & (RdW != REGW'(REG_X0)) & ~forceSlot;
    assign pop       = rst & ~pipeWrite & ~fifoEmpty;

    wb_result_fifo #(
        .XLEN (XLEN),
        .REGW (REGW),
        .DEPTH(DEPTH)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pushRd_i  (MduRd),
        .pushData_i(MduResult),
        .pop_i     (pop),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .headRd_o  (headRd),
        .headData_o(headResult),
        .valid_o   (validVec),
        .rdVec_o   (rdVec)
    );

    always_comb begin
        RegWriteR = 1'b0;
        RdR       = '0;
        ResultR   = '0;
        if (pipeWrite) begin
            RegWriteR = 1'b1;
            RdR       = RdW;
            ResultR   = ResultW;
        end else if (pop) begin
            RegWriteR = 1'b1;
            RdR       = headRd;
            ResultR   = headResult;
        end
    end

    always_comb begin
        logic [REGW-1:0] entRd;
        entRd      = '0;
        HazardPend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            entRd = rdVec[i*REGW +: REGW];
            if (validVec[i] && (entRd != REGW'(REG_X0)) &&
                ((entRd == Rs1D) || (entRd == Rs2D) || (entRd == RdD))) begin
                HazardPend = 1'b1;
            end
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);

    arb_state_e     state_q;
    logic [WCW-1:0] waitCnt_q;
    logic           stall_q;
    logic           entriesRemain;

    // After the forced pop, another entry is left if more than one was valid or one arrives now.
    assign entriesRemain = (|(validVec & (validVec - DEPTH'(1)))) | push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (pop) begin
                waitCnt_q <= '0;
            end else if (!fifoEmpty) begin
                waitCnt_q <= waitCnt_q + WCW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) state_q <= PEND;
                end
                PEND: begin
                    if (fifoEmpty) begin
                        state_q <= IDLE;
                    end else if ((waitCnt_q == WCW'(MAX_WAIT - 1)) && !pop) begin
                        state_q <= FORCE;
                        stall_q <= 1'b1;
                    end
                end
                FORCE: begin
                    state_q <= entriesRemain ? PEND : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign forceSlot = stall_q;
    assign StallWB   = stall_q;
`else
    assign forceSlot = 1'b0;
    assign StallWB   = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic        MduValid = 1'b0;
    logic        MduReady;
    logic [4:0]  MduRd = '0;
    logic [31:0] MduResult = '0;
    logic [4:0]  Rs1D = '0;
    logic [4:0]  Rs2D = '0;
    logic [4:0]  RdD = '0;
    logic        HazardPend;
    logic        StallWB;
    logic        RegWriteR;
    logic [4:0]  RdR;
    logic [31:0] ResultR;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .MduValid  (MduValid),
        .MduReady  (MduReady),
        .MduRd     (MduRd),
        .MduResult (MduResult),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .HazardPend(HazardPend),
        .StallWB   (StallWB),
        .RegWriteR (RegWriteR),
        .RdR       (RdR),
        .ResultR   (ResultR)
    );

    int checks = 0;
    int errors = 0;

    // One comparison: bump the counters and report a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
    task automatic applyStimulus(input bit rw, input logic [4:0] rd, input logic [31:0] res,
                                 input bit mv, input logic [4:0] mrd, input logic [31:0] mres,
                                 input logic [4:0] rs1);
        @(posedge clk);
        #1;
        RegWriteW = rw;
        RdW       = rd;
        ResultW   = res;
        MduValid  = mv;
        MduRd     = mrd;
        MduResult = mres;
        Rs1D      = rs1;
        Rs2D      = '0;
        RdD       = '0;
        @(negedge clk);
    endtask

    // Reference model: FIFO of buffered results plus the number of cycles the head has gone unserved.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   age = 0;
    bit   prevStall = 1'b0;

    // Every falling edge: predict outputs from the model and the current inputs, compare, then advance.
    initial begin
        bit          expStall;
        bit          expReady;
        bit          pipe;
        bit          popd;
        bit          expWe;
        logic [4:0]  expRd;
        logic [31:0] expRes;
        bit          expHaz;
        bit          wasNonEmpty;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rst_RegWriteR", {31'b0, RegWriteR}, 32'd0);
                checkOutput("rst_MduReady", {31'b0, MduReady}, 32'd0);
                checkOutput("rst_StallWB", {31'b0, StallWB}, 32'd0);
                checkOutput("rst_HazardPend", {31'b0, HazardPend}, 32'd0);
                checkOutput("rst_RdR", {27'b0, RdR}, 32'd0);
                checkOutput("rst_ResultR", ResultR, 32'd0);
                q.delete();
                age       = 0;
                prevStall = 1'b0;
            end else begin
                expStall = STARVE && (q.size() > 0) && (age >= MAX_WAIT);
                expReady = (q.size() < DEPTH);
                pipe     = RegWriteW && (RdW != 5'd0) && !expStall;
                popd     = !pipe && (q.size() > 0);
                expWe    = 1'b0;
                expRd    = '0;
                expRes   = '0;
                if (pipe) begin
                    expWe  = 1'b1;
                    expRd  = RdW;
                    expRes = ResultW;
                end else if (popd) begin
                    expWe  = 1'b1;
                    expRd  = q[0].rd;
                    expRes = q[0].data;
                end
                expHaz = 1'b0;
                foreach (q[j]) begin
                    if ((Rs1D != 5'd0 && q[j].rd == Rs1D) ||
                        (Rs2D != 5'd0 && q[j].rd == Rs2D) ||
                        (RdD  != 5'd0 && q[j].rd == RdD)) expHaz = 1'b1;
                end
                checkOutput("model_RegWriteR", {31'b0, RegWriteR}, {31'b0, expWe});
                if (expWe) begin
                    checkOutput("model_RdR", {27'b0, RdR}, {27'b0, expRd});
                    checkOutput("model_ResultR", ResultR, expRes);
                end
                checkOutput("model_MduReady", {31'b0, MduReady}, {31'b0, expReady});
                checkOutput("model_StallWB", {31'b0, StallWB}, {31'b0, expStall});
                checkOutput("model_HazardPend", {31'b0, HazardPend}, {31'b0, expHaz});

                wasNonEmpty = (q.size() > 0);
                if (popd) begin
                    void'(q.pop_front());
                    age = 0;
                end else if (wasNonEmpty) begin
                    age++;
                end
                if (MduValid && expReady && MduRd != 5'd0) begin
                    q.push_back('{rd: MduRd, data: MduResult});
                end
                prevStall = expStall;
            end
        end
    end

    // Main sequence: directed scenarios with hand-computed expectations, then randomized traffic.
    initial begin
        logic [4:0] pipeRd;

        $display("[TB] reset with requests pending");
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'h55, 5'd5);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd5, 32'h55, 5'd5);
        checkOutput("reset_RegWriteR", {31'b0, RegWriteR}, 32'd0);
        checkOutput("reset_MduReady", {31'b0, MduReady}, 32'd0);
        checkOutput("reset_StallWB", {31'b0, StallWB}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        MduValid  = 1'b0;
        MduRd     = '0;
        MduResult = '0;
        Rs1D      = '0;
        @(negedge clk);
        checkOutput("release_MduReady", {31'b0, MduReady}, 32'd1);

        $display("[TB] idle drain");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, 5'd0);
        checkOutput("drain_push_noWrite", {31'b0, RegWriteR}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5);
        checkOutput("drain_RegWriteR", {31'b0, RegWriteR}, 32'd1);
        checkOutput("drain_RdR", {27'b0, RdR}, 32'd5);
        checkOutput("drain_ResultR", ResultR, 32'h1234);
        checkOutput("drain_HazardPend", {31'b0, HazardPend}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5);
        checkOutput("drain_empty_after", {31'b0, RegWriteR}, 32'd0);
        checkOutput("drain_hazard_clear", {31'b0, HazardPend}, 32'd0);

        $display("[TB] priority and backpressure");
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33, 5'd0);
        checkOutput("prio_c0_RdR", {27'b0, RdR}, 32'd7);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd4, 32'h44, 5'd0);
        checkOutput("prio_c1_RdR", {27'b0, RdR}, 32'd7);
        checkOutput("prio_c1_MduReady", {31'b0, MduReady}, 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 5'd4);
        checkOutput("prio_c2_RdR", {27'b0, RdR}, 32'd7);
        checkOutput("prio_full_MduReady", {31'b0, MduReady}, 32'd0);
        checkOutput("prio_HazardPend_rs4", {31'b0, HazardPend}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("prio_drain3_RdR", {27'b0, RdR}, 32'd3);
        checkOutput("prio_drain3_ResultR", ResultR, 32'h33);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("prio_drain4_RdR", {27'b0, RdR}, 32'd4);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("prio_drained", {31'b0, RegWriteR}, 32'd0);

        $display("[TB] starvation");
        applyStimulus(1'b1, 5'd20, 32'h2000, 1'b1, 5'd9, 32'hCAFE, 5'd0);
        checkOutput("starve_push_RdR", {27'b0, RdR}, 32'd20);
        for (int k = 1; k <= 7; k++) begin
            // The cycle after a forced slot re-presents the stalled pipeline write.
            pipeRd = (k == 6) ? 5'd25 : 5'(20 + k);
            applyStimulus(1'b1, pipeRd, {27'b0, pipeRd}, 1'b0, 5'd0, 32'h0, 5'd0);
            if (STARVE && k == 5) begin
                checkOutput("starve_force_StallWB", {31'b0, StallWB}, 32'd1);
                checkOutput("starve_force_RdR", {27'b0, RdR}, 32'd9);
                checkOutput("starve_force_ResultR", ResultR, 32'hCAFE);
            end else begin
                checkOutput("starve_StallWB", {31'b0, StallWB}, 32'd0);
                checkOutput("starve_pipe_RdR", {27'b0, RdR}, {27'b0, pipeRd});
            end
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        if (STARVE) begin
            checkOutput("starve_after_idle", {31'b0, RegWriteR}, 32'd0);
        end else begin
            checkOutput("starve_late_RegWriteR", {31'b0, RegWriteR}, 32'd1);
            checkOutput("starve_late_RdR", {27'b0, RdR}, 32'd9);
            checkOutput("starve_late_ResultR", ResultR, 32'hCAFE);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("starve_empty", {31'b0, RegWriteR}, 32'd0);

        $display("[TB] x0 destinations");
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0);
        checkOutput("x0_RegWriteR", {31'b0, RegWriteR}, 32'd0);
        checkOutput("x0_HazardPend", {31'b0, HazardPend}, 32'd0);
        checkOutput("x0_MduReady", {31'b0, MduReady}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("x0_not_buffered", {31'b0, RegWriteR}, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (i % 700 == 350) rst = 1'b0;
            else if (i % 700 == 352) rst = 1'b1;
            if (!prevStall) begin
                RegWriteW = ($urandom_range(0, 99) < 80);
                RdW       = 5'($urandom_range(0, 31));
                ResultW   = $urandom;
            end
            MduValid  = 1'($urandom_range(0, 1));
            MduRd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MduResult = $urandom;
            Rs1D      = 5'($urandom_range(0, 31));
            Rs2D      = 5'($urandom_range(0, 31));
            RdD       = 5'($urandom_range(0, 31));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
